ls_quad_access: RTL and testbench
=================================

Name: ls_quad_access

Overview:
- Initiator side of the SPU Local Store word interface: the SPU load/store path issues one 128-bit quadword request.
- The block sequences four 32-bit word accesses to the 16 KB local store memory, which has a 32-bit word port.
- On a load, it assembles the four words into a 128-bit result; on a store, it splits the quadword into four word writes.
- It sits between the cellspu execute/load-store stage and the local store.

Parameters:
- WIDTH, 32, memory word width and address width (fixed at 32 for this design).
- LS_BYTES, 16384, local store size in bytes; power of two; addresses wrap modulo this value.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_write  input  1  1 = store quadword, 0 = load quadword.
- req_addr  input  WIDTH  byte address; bits [3:0] ignored.
- req_wdata  input  128  store data; bits [127:96] = lowest-addressed word (big-endian).
- rsp_valid  output  1  one-cycle pulse; transaction complete.
- rsp_rdata  output  128  load data, same word order as req_wdata; holds its value until the next load completes.
- memwrite  output  1  word write strobe to local store.
- adr  output  WIDTH  byte address to local store; always word aligned.
- writedata  output  WIDTH  word to write.
- memdata  input  WIDTH  read word; combinational from adr in the same cycle.

Behaviour:
- Reset values: state=IDLE, beat=0, memwrite=0, adr=0, writedata=0, rsp_valid=0, rsp_rdata=0. req_ready=1, since it is decoded from IDLE.
- State machine: IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - Handshake fires on a posedge with req_valid && req_ready.
  - Latch base = req_addr & (LS_BYTES-1) & ~15, plus req_write and req_wdata.
  - Go to XFER with beat=0.
- XFER, beats 0..3, one per cycle:
  - adr = (base + 4*beat) mod LS_BYTES.
  - Store: memwrite=1; writedata = word[beat], where word 0 = wdata[127:96].
  - Load: memwrite=0; capture memdata into rsp_rdata slot[beat] at the posedge ending that beat.
  - After beat 3, go to DONE.
- DONE: rsp_valid=1 for exactly one cycle; memwrite=0; return to IDLE.
- Latency: handshake at edge T; beats occupy cycles T+1..T+4; rsp_valid in cycle T+5; req_ready high again from T+6. Throughput is 1 request per 6 cycles.
- All memory-side outputs are registered. No glitching on memwrite; memwrite is 0 outside XFER.
- req_* inputs are ignored outside IDLE. Inputs may change freely after the handshake because data is latched.
- Wrap-around: a quadword never straddles the LS end (base is 16-byte aligned, LS_BYTES is a multiple of 16). An address ≥ LS_BYTES aliases modulo LS_BYTES.
- Load of rsp_rdata: slots are updated only during load beats. Stores leave rsp_rdata unchanged.
- Reset mid-operation:
  - Immediate abort: memwrite drops asynchronously; no rsp_valid.
  - Words already written by a store remain in memory; partial load data is discarded (rsp_rdata cleared to 0).

Optional Feature:
- Macro: LSQA_WORD_MASK_EN.
- Defined:
  - Adds input req_wmask[3:0], latched at the handshake; bit 3 = word 0.
  - On a store, memwrite is asserted for beat i only if the mask bit for word i is set. adr still steps through all 4 beats, so latency is unchanged.
  - Loads ignore the mask.
- Undefined: the port is absent and all four words are written on a store.

Decomposition:
- Package ls_pkg: the state enum (IDLE/XFER/DONE), QW_BYTES=16, WORDS_PER_QW=4, and the word-slot index function (beat -> bit range).
- One natural sub-module, ls_qw_pack: a 128-bit holding register with 32-bit slot write enable, used for rsp_rdata assembly.
- Splitting store data is pure muxing and stays inline.

Test Plan:
- Store to 0x0000_0010 with data 0x11111111_22222222_33333333_44444444, then load from 0x10 -> memwrite pulses at adr 0x10, 0x14, 0x18, 0x1C in order; load returns the identical 128-bit value; rsp_valid 5 cycles after each handshake.
- Load from req_addr 0x0000_401B -> adr sequence 0x10, 0x14, 0x18, 0x1C (masked and aligned); data matches memory words 4..7.
- Hold req_valid=1 continuously for two loads -> req_ready low for cycles T+1..T+5; second handshake at T+6; no request lost or duplicated.
- Assert reset_n=0 during beat 2 of a store -> memwrite=0 immediately; words 0 and 1 written, words 2 and 3 unchanged; rsp_valid never pulses; next request after release behaves normally.
- Store followed by rsp_rdata check -> rsp_rdata unchanged by the store; rsp_valid still pulses once.
- LSQA_WORD_MASK_EN with mask 4'b1010 on store to 0x100 -> memwrite only at adr 0x100 and 0x108; words at 0x104 and 0x10C unchanged.

Source files
------------

// File: rtl/ls_quad_access_pkg.sv
// Shared types for the local store quadword sequencer.
// States, quadword geometry and the beat-to-slot mapping.
package ls_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int QW_BYTES     = 16;
    localparam int WORDS_PER_QW = 4;
    localparam int WORD_BITS    = 32;
    localparam int QW_BITS      = 128;

    // Beat 0 is the lowest-addressed word, held in bits [127:96].
    function automatic logic [6:0] slot_lsb(input logic [1:0] beat);
        return 7'd96 - {beat, 5'b00000};
    endfunction

endpackage

// File: rtl/ls_quad_access_if.sv
// Quadword request/response bus between load/store stage and sequencer.
// Optional req_wmask is present when LSQA_WORD_MASK_EN is defined.
interface ls_quad_access_if #(
    parameter int WIDTH = 32
);
    import ls_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [WIDTH-1:0]     req_addr;
    logic [QW_BITS-1:0]   req_wdata;
`ifdef LSQA_WORD_MASK_EN
    logic [3:0]           req_wmask;
`endif
    logic                 rsp_valid;
    logic [QW_BITS-1:0]   rsp_rdata;

    modport master (
`ifdef LSQA_WORD_MASK_EN
        output req_wmask,
`endif
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
`ifdef LSQA_WORD_MASK_EN
        input  req_wmask,
`endif
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/ls_quad_access_qw_pack.sv
// 128-bit holding register written one 32-bit slot at a time.
// Used to assemble load data; cleared by reset.
module ls_qw_pack
    import ls_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [1:0]           slot,
    input  logic [WORD_BITS-1:0] din,
    output logic [QW_BITS-1:0]   q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (we) begin
            q[slot_lsb(slot) +: WORD_BITS] <= din;
        end
    end

endmodule

// File: rtl/ls_quad_access.sv
// Sequences one 128-bit local store request as four 32-bit word beats.
// Define LSQA_WORD_MASK_EN to add a per-word store mask (req_wmask).
module ls_quad_access
    import ls_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LS_BYTES = 16384
) (
    input  logic             clk,
    input  logic             reset_n,
    ls_quad_access_if.slave  bus,
    output logic             memwrite,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] memdata
);

    localparam logic [WIDTH-1:0] LS_MASK = WIDTH'(LS_BYTES - 1);
    localparam logic [WIDTH-1:0] ALIGN   = ~WIDTH'(QW_BYTES - 1);

    state_t               state_q, state_d;
    logic [1:0]           beat_q, beat_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic                 wr_q, wr_d;
    logic [QW_BITS-1:0]   wdata_q, wdata_d;
    logic [3:0]           mask_q, mask_d;
    logic                 memwrite_d;
    logic [WIDTH-1:0]     adr_d;
    logic [WIDTH-1:0]     writedata_d;
    logic                 cap;
    logic [QW_BITS-1:0]   rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            base_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            mask_q    <= '0;
            memwrite  <= 1'b0;
            adr       <= '0;
            writedata <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            memwrite  <= memwrite_d;
            adr       <= adr_d;
            writedata <= writedata_d;
        end
    end

    // Memory-side outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        memwrite_d  = 1'b0;
        adr_d       = adr;
        writedata_d = writedata;
        cap         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d     = XFER;
                    beat_d      = 2'd0;
                    base_d      = bus.req_addr & LS_MASK & ALIGN;
                    wr_d        = bus.req_write;
                    wdata_d     = bus.req_wdata;
`ifdef LSQA_WORD_MASK_EN
                    mask_d      = bus.req_wmask;
`else
                    mask_d      = 4'hF;
`endif
                    adr_d       = base_d;
                    writedata_d = bus.req_wdata[slot_lsb(2'd0) +: WORD_BITS];
                    memwrite_d  = bus.req_write & mask_d[3];
                end
            end
            XFER: begin
                cap = ~wr_q;
                if (beat_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    beat_d      = beat_q + 2'd1;
                    adr_d       = (base_q + WIDTH'({beat_d, 2'b00})) & LS_MASK;
                    writedata_d = wdata_q[slot_lsb(beat_d) +: WORD_BITS];
                    memwrite_d  = wr_q & mask_q[~beat_d];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ls_qw_pack u_pack (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (cap),
        .slot    (beat_q),
        .din     (memdata),
        .q       (rdata)
    );

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_rdata = rdata;

endmodule

// File: tb/tb_ls_quad_access.sv
// Self-checking bench for ls_quad_access with a word memory model.
// Table-driven transactions plus back-to-back, reset-abort and mask cases.
module tb_ls_quad_access;
    import ls_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ls_quad_access_if #(.WIDTH(32)) bus ();

    logic        memwrite;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [31:0] memdata;

    ls_quad_access #(.WIDTH(32), .LS_BYTES(16384)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .memdata   (memdata)
    );

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];

    assign memdata = mem[adr[13:2]];
    always @(posedge clk) if (memwrite) mem[adr[13:2]] = writedata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [127:0] rd; int c; } rsp_t;
    wr_t  wq[$];
    rsp_t rq[$];
    logic [127:0] last_rd = '0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s act=event exp=none", name);
    endtask

    always @(negedge clk) begin
        wr_t  w;
        rsp_t r;
        if (reset_n) begin
            if (memwrite) begin
                if (wq.size() == 0) fail("unexpected_write");
                else begin
                    w = wq.pop_front();
                    chk("wr_adr", adr, w.a);
                    chk("wr_data", writedata, w.d);
                end
            end
            if (bus.rsp_valid) begin
                if (rq.size() == 0) fail("unexpected_rsp");
                else begin
                    r = rq.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, r.rd);
                    chk("rsp_cycle", cyc, r.c);
                end
            end
        end
    end

    function automatic logic [127:0] qw_ref(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'h3FF0;
        return {ref_mem[b[13:2]], ref_mem[b[13:2]+1],
                ref_mem[b[13:2]+2], ref_mem[b[13:2]+3]};
    endfunction

    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [127:0] d, input logic [3:0] m,
                         input logic [127:0] exp,
                         output int hs, output int waited);
        logic [3:0]  em;
        logic [31:0] b;
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
`ifdef LSQA_WORD_MASK_EN
        bus.req_wmask = m;
        em = m;
`else
        em = m | 4'hF;
`endif
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        hs = cyc;
        if (!bus.req_ready) begin
            fail("ready_timeout");
            hs = -1;
            return;
        end
        b = a & 32'h3FF0;
        if (w) begin
            for (int i = 0; i < 4; i++) begin
                if (em[3-i]) begin
                    wq.push_back('{b + 32'(4*i), d[slot_lsb(2'(i)) +: 32]});
                    ref_mem[b[13:2] + 12'(i)] = d[slot_lsb(2'(i)) +: 32];
                end
            end
            rq.push_back('{last_rd, hs + 5});
        end else begin
            rq.push_back('{exp, hs + 5});
            last_rd = exp;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic         w;
        logic [31:0]  a;
        logic [127:0] d;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int hs, hs2, wt;
        logic [127:0] e;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef LSQA_WORD_MASK_EN
        bus.req_wmask = 4'hF;
`endif
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end

        tbl[0] = '{1'b1, 32'h0000_0010, 128'h11111111_22222222_33333333_44444444, '0};
        tbl[1] = '{1'b0, 32'h0000_0010, '0, 128'h11111111_22222222_33333333_44444444};
        tbl[2] = '{1'b0, 32'h0000_401B, '0, 128'h11111111_22222222_33333333_44444444};
        tbl[3] = '{1'b1, 32'h0000_3FF0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, '0};
        tbl[4] = '{1'b0, 32'h0000_7FF4, '0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF};
        tbl[5] = '{1'b0, 32'h0000_0200, '0, 128'hC0DE0080_C0DE0081_C0DE0082_C0DE0083};
        tbl[6] = '{1'b1, 32'h0000_0020, 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000, '0};
        tbl[7] = '{1'b0, 32'h0000_002C, '0, 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000};
        tbl[8] = '{1'b1, 32'hFFFF_FF40, 128'h01010101_02020202_03030303_04040404, '0};
        tbl[9] = '{1'b0, 32'h0000_3F40, '0, 128'h01010101_02020202_03030303_04040404};

        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_memwrite", memwrite, 0);
        chk("rst_adr", adr, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].w, tbl[i].a, tbl[i].d, 4'hF, tbl[i].exp, hs, wt);
            bus.req_valid = 1'b0;
        end

        // Back-to-back loads with req_valid held high.
        issue(1'b0, 32'h10, '0, 4'hF, 128'h11111111_22222222_33333333_44444444, hs, wt);
        issue(1'b0, 32'h20, '0, 4'hF, 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000, hs2, wt);
        bus.req_valid = 1'b0;
        chk("b2b_gap", hs2 - hs, 6);
        chk("b2b_ready_low", wt, 5);

        // Reset during beat 2 of a store.
        e = qw_ref(32'h300);
        issue(1'b1, 32'h300, 128'h900D0000_900D0001_900D0002_900D0003, 4'hF, '0, hs, wt);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_memwrite", memwrite, 0);
        chk("abort_rdata", bus.rsp_rdata, 0);
        wq.delete();
        rq.delete();
        ref_mem[12'hC2] = e[63:32];
        ref_mem[12'hC3] = e[31:0];
        last_rd = '0;
        repeat (2) @(negedge clk);
        chk("abort_no_rsp", bus.rsp_valid, 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        e = {32'h900D0000, 32'h900D0001, 32'hC0DE00C2, 32'hC0DE00C3};
        issue(1'b0, 32'h300, '0, 4'hF, e, hs, wt);
        bus.req_valid = 1'b0;
        chk("abort_mem_ref", e, qw_ref(32'h300));
        issue(1'b1, 32'h40, 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C, 4'hF, '0, hs, wt);
        issue(1'b0, 32'h40, '0, 4'hF, 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C, hs, wt);
        bus.req_valid = 1'b0;

`ifdef LSQA_WORD_MASK_EN
        issue(1'b1, 32'h100, 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333, 4'b1010, '0, hs, wt);
        bus.req_valid = 1'b0;
        e = {32'hAAAA0000, 32'hC0DE0041, 32'hCCCC2222, 32'hC0DE0043};
        issue(1'b0, 32'h100, '0, 4'b0000, e, hs, wt);
        bus.req_valid = 1'b0;
`endif

        wt = 0;
        while ((rq.size() != 0 || wq.size() != 0) && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        if (rq.size() != 0 || wq.size() != 0) fail("drain_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
